w_mux_arb: RTL and testbench
============================

W_MUX_ARB -- requirements
Module: w_mux_arb

Interface
REQ-001 SHALL have parameter NUM_M, default 2, number of masters (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, write-data width; STRB_W = DATA_W/8 derived.
REQ-003 SHALL have parameter QDEPTH, default 4, grant-queue depth (power of 2, >=2); MID_W = $clog2(NUM_M).
REQ-004 SHALL have ports:
- ACLK  in  1  clock, rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- aw_push  in  1  AW handshake completed at slave (AWVALID&AWREADY).
- aw_mid  in  MID_W  master index granted on that AW.
- aw_full  out  1  grant queue full; AW arbiter holds AWREADY low.
- WDATA_M  in  NUM_M*DATA_W  packed master write data, master i at slice i.
- WSTRB_M  in  NUM_M*STRB_W  packed master strobes.
- WLAST_M  in  NUM_M  per-master last flag.
- WVALID_M  in  NUM_M  per-master valid.
- WREADY_M  out  NUM_M  per-master ready.
- WDATA  out  DATA_W  to slave; WSTRB  out  STRB_W; WLAST  out  1; WVALID  out  1.
- WREADY  in  1  from slave.
- busy  out  1  queue non-empty or burst in flight.

Function
REQ-005 SHALL hold AW grants in a FIFO of QDEPTH MID_W-bit entries, count 0..QDEPTH; aw_full = (count==QDEPTH), registered.
REQ-006 SHALL push aw_mid on aw_push when count<QDEPTH and aw_mid<NUM_M; otherwise SHALL drop the push, contents unchanged.
REQ-007 SHALL select head entry h as active master when count>0; data path WDATA/WSTRB/WLAST from master h, WVALID=WVALID_M[h].
REQ-008 SHALL drive WREADY_M[h]=WREADY (combinational path) and WREADY_M[i]=0 for all i!=h.
REQ-009 SHALL, when count==0, drive WVALID=0, WDATA=0, WSTRB=0, WLAST=0, WREADY_M all 0.
REQ-010 SHALL pop head on the cycle WVALID_M[h]&WREADY_M[h]&WLAST_M[h] is high; next master selected in the following cycle, no bubble beyond that.
REQ-011 SHALL keep count unchanged on simultaneous accepted push and pop; pop from count 1 with push leaves new entry as head.
REQ-012 SHALL wrap read/write pointers modulo QDEPTH.
REQ-013 SHALL ignore WVALID_M of non-head masters; their beats stall until they become head.
REQ-014 SHALL keep order of W bursts equal to AW accept order (AXI no-interleave).
REQ-015 SHALL assert busy whenever count>0 or the register slice (REQ-019) holds data.

Reset
REQ-016 SHALL, on ARESET high, asynchronously clear count, pointers, slice valid flags; aw_full=0, busy=0, WVALID=0, WDATA=0, WSTRB=0, WLAST=0, WREADY_M=0.
REQ-017 SHALL discard any queued grants and partial burst on reset mid-operation; first grant after release starts fresh.
REQ-018 SHALL accept pushes on the first rising ACLK edge after ARESET deasserts.

Configuration
REQ-019 SHALL, with macro W_MUX_REG_SLICE_EN defined, insert a 2-entry skid buffer between selected master and slave: outputs registered, 1-cycle latency, WREADY_M[h] = slice not full (no WREADY combinational path), full throughput; grant popped when WLAST beat enters slice.
REQ-020 SHALL, without W_MUX_REG_SLICE_EN, use the zero-latency combinational path of REQ-007/008.

Verification
REQ-021 SHALL cover: NUM_M=2, push mid 1, M1 sends 4 beats (last on beat 4), WREADY=1 -> 4 beats out, WREADY_M=2'b10, queue empty, busy=0 next cycle.
REQ-022 SHALL cover: push mid 0 then 1, both masters WVALID=1 -> all M0 beats precede M1, WREADY_M[1]=0 until M0 WLAST accepted.
REQ-023 SHALL cover: QDEPTH=4 pushes with no W traffic -> aw_full=1; 5th push dropped; one burst pop -> aw_full=0.
REQ-024 SHALL cover: count==1, WLAST accepted and aw_push same cycle -> count stays 1, new master becomes head next cycle.
REQ-025 SHALL cover: ARESET pulsed mid-burst (beat 2 of 4) -> WVALID=0, count=0, busy=0 immediately, no further beats forwarded.
REQ-026 SHALL cover: W_MUX_REG_SLICE_EN defined, WREADY toggling 1/0 -> no beat lost or duplicated, first beat on WVALID one cycle after WVALID_M.

Source files
------------

// File: rtl/w_mux_arb.sv
// w_mux_arb: AXI write-data multiplexer steered by a FIFO of AW grants.
// Each granted master ID is queued in AW accept order. The head entry selects
// which master's W channel reaches the slave, and it is popped on its WLAST beat.
// Optional feature: define W_MUX_REG_SLICE_EN to place a 2-entry skid buffer
// between the selected master and the slave. This gives registered outputs and
// removes the combinational WREADY path.
module w_mux_arb #(
  parameter int NUM_M  = 2,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 4,
  localparam int STRB_W = DATA_W / 8,
  localparam int MID_W  = $clog2(NUM_M)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      aw_push,
  input  logic [MID_W-1:0]          aw_mid,
  output logic                      aw_full,
  input  logic [NUM_M*DATA_W-1:0]   WDATA_M,
  input  logic [NUM_M*STRB_W-1:0]   WSTRB_M,
  input  logic [NUM_M-1:0]          WLAST_M,
  input  logic [NUM_M-1:0]          WVALID_M,
  output logic [NUM_M-1:0]          WREADY_M,
  output logic [DATA_W-1:0]         WDATA,
  output logic [STRB_W-1:0]         WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic                      busy
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);
  localparam logic [MID_W:0]   MID_LIM  = (MID_W + 1)'(NUM_M);

  logic [MID_W-1:0]  gq_mem [QDEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              active;
  logic              mid_ok;
  logic              push_ok;
  logic              pop;
  logic [MID_W-1:0]  head;
  logic [NUM_M-1:0]  head_hit;
  logic [DATA_W-1:0] sel_data;
  logic [STRB_W-1:0] sel_strb;
  logic              sel_last;
  logic              sel_valid;

  assign head    = gq_mem[rd_ptr];
  assign active  = (count != {CNT_W{1'b0}});
  assign mid_ok  = ({1'b0, aw_mid} < MID_LIM);
  // A push is refused when the queue is full, even if a pop happens in the same cycle.
  assign push_ok = aw_push & (count != FULL_CNT) & mid_ok;
  assign aw_full = full_q;

  // Select the head master's W channel with a one-hot AND-OR mux.
  always_comb begin
    head_hit  = {NUM_M{1'b0}};
    sel_data  = {DATA_W{1'b0}};
    sel_strb  = {STRB_W{1'b0}};
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      head_hit[i] = (head == MID_W'(i));
      sel_data    = sel_data | ({DATA_W{head_hit[i]}} & WDATA_M[i*DATA_W +: DATA_W]);
      sel_strb    = sel_strb | ({STRB_W{head_hit[i]}} & WSTRB_M[i*STRB_W +: STRB_W]);
      sel_last    = sel_last | (head_hit[i] & WLAST_M[i]);
      sel_valid   = sel_valid | (head_hit[i] & WVALID_M[i]);
    end
  end

  // Compute the next queue occupancy. A push and a pop in the same cycle cancel out.
  always_comb begin
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Update the queue pointers, the occupancy count and the registered full flag.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
      full_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == FULL_CNT);
    end
  end

  // Store accepted grant IDs. The pointers wrap naturally because QDEPTH is a power of 2.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < QDEPTH; i++) gq_mem[i] <= {MID_W{1'b0}};
    end else if (push_ok) begin
      gq_mem[wr_ptr] <= aw_mid;
    end
  end

`ifdef W_MUX_REG_SLICE_EN
  logic [DATA_W-1:0] sl_data [2];
  logic [STRB_W-1:0] sl_strb [2];
  logic [1:0]        sl_last;
  logic [1:0]        sl_cnt;
  logic              sl_rd;
  logic              sl_wr;
  logic              in_ready;
  logic              in_fire;
  logic              out_valid;
  logic              out_fire;

  assign in_ready  = active & (sl_cnt != 2'd2);
  assign in_fire   = in_ready & sel_valid;
  assign out_valid = (sl_cnt != 2'd0);
  assign out_fire  = out_valid & WREADY;
  // The grant is retired as soon as its last beat is captured by the buffer.
  assign pop       = in_fire & sel_last;
  assign busy      = active | out_valid;

  // Hold up to two beats so the selected master can stream at full rate.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sl_data[0] <= {DATA_W{1'b0}};
      sl_data[1] <= {DATA_W{1'b0}};
      sl_strb[0] <= {STRB_W{1'b0}};
      sl_strb[1] <= {STRB_W{1'b0}};
      sl_last    <= 2'b00;
      sl_cnt     <= 2'd0;
      sl_rd      <= 1'b0;
      sl_wr      <= 1'b0;
    end else begin
      if (in_fire) begin
        sl_data[sl_wr] <= sel_data;
        sl_strb[sl_wr] <= sel_strb;
        sl_last[sl_wr] <= sel_last;
        sl_wr          <= ~sl_wr;
      end
      if (out_fire) sl_rd <= ~sl_rd;
      case ({in_fire, out_fire})
        2'b10:   sl_cnt <= sl_cnt + 2'd1;
        2'b01:   sl_cnt <= sl_cnt - 2'd1;
        default: sl_cnt <= sl_cnt;
      endcase
    end
  end

  // Feed the slave from the buffer. A master sees only whether the buffer has space.
  always_comb begin
    WREADY_M = head_hit & {NUM_M{in_ready}};
    if (out_valid) begin
      WVALID = 1'b1;
      WDATA  = sl_data[sl_rd];
      WSTRB  = sl_strb[sl_rd];
      WLAST  = sl_last[sl_rd];
    end else begin
      WVALID = 1'b0;
      WDATA  = {DATA_W{1'b0}};
      WSTRB  = {STRB_W{1'b0}};
      WLAST  = 1'b0;
    end
  end
`else
  assign pop  = active & sel_valid & WREADY & sel_last;
  assign busy = active;

  // Pass the head master straight through. Drive all outputs to zero when no grant is queued.
  always_comb begin
    if (active) begin
      WREADY_M = head_hit & {NUM_M{WREADY}};
      WVALID   = sel_valid;
      WDATA    = sel_data;
      WSTRB    = sel_strb;
      WLAST    = sel_last;
    end else begin
      WREADY_M = {NUM_M{1'b0}};
      WVALID   = 1'b0;
      WDATA    = {DATA_W{1'b0}};
      WSTRB    = {STRB_W{1'b0}};
      WLAST    = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_w_mux_arb.sv
// tb_w_mux_arb: randomized self-checking bench for w_mux_arb.
// The reference model keeps the AW grant order, per-master burst queues and
// the expected slave-side beat stream.
module tb_w_mux_arb;
  localparam int NUM_M  = 3;
  localparam int DATA_W = 16;
  localparam int QDEPTH = 4;
  localparam int STRB_W = DATA_W / 8;
  localparam int MID_W  = $clog2(NUM_M);
  localparam int BW     = DATA_W + STRB_W + 1;
`ifdef W_MUX_REG_SLICE_EN
  localparam bit SLICE = 1'b1;
`else
  localparam bit SLICE = 1'b0;
`endif

  logic                    ACLK = 1'b0;
  logic                    ARESET;
  logic                    aw_push;
  logic [MID_W-1:0]        aw_mid;
  logic                    aw_full;
  logic [NUM_M*DATA_W-1:0] WDATA_M;
  logic [NUM_M*STRB_W-1:0] WSTRB_M;
  logic [NUM_M-1:0]        WLAST_M;
  logic [NUM_M-1:0]        WVALID_M;
  logic [NUM_M-1:0]        WREADY_M;
  logic [DATA_W-1:0]       WDATA;
  logic [STRB_W-1:0]       WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic                    busy;

  w_mux_arb #(.NUM_M(NUM_M), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .aw_push(aw_push), .aw_mid(aw_mid), .aw_full(aw_full),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
    .WREADY(WREADY), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: grant order, per-master pending beats, expected slave stream
  int             gq[$];
  logic [BW-1:0]  mq[NUM_M][$];
  logic [BW-1:0]  exp_out[$];
  int             inflight;
  int             nfire;

  // per-step observations
  logic [NUM_M-1:0] rdy_obs, rdy_exp;
  logic             vld_obs, vld_exp, fire, idle_chk;
  logic [BW-1:0]    beat_obs, beat_exp, idle_obs;
  logic             full_obs, full_exp, busy_obs, busy_exp;

  task automatic clear_model();
    gq.delete();
    for (int m = 0; m < NUM_M; m++) mq[m].delete();
    exp_out.delete();
    inflight = 0;
  endtask

  // one clock: sample registered outputs, drive inputs, sample comb outputs, advance model
  task automatic step(input bit push, input int mid, input int blen,
                      input logic [NUM_M-1:0] vmask, input bit wready);
    logic [BW-1:0] b;
    bit            accept;
    logic          rdy_bit;
    @(negedge ACLK);
    full_obs = aw_full;
    full_exp = (gq.size() == QDEPTH);
    busy_obs = busy;
    busy_exp = (gq.size() != 0) || (inflight != 0);
    aw_push = push;
    aw_mid  = mid[MID_W-1:0];
    WREADY  = wready;
    for (int m = 0; m < NUM_M; m++) begin
      if (vmask[m] && mq[m].size() != 0) begin
        WVALID_M[m] = 1'b1;
        b = mq[m][0];
      end else begin
        WVALID_M[m] = 1'b0;
        b = BW'($urandom);
      end
      WDATA_M[m*DATA_W +: DATA_W] = b[BW-1 -: DATA_W];
      WSTRB_M[m*STRB_W +: STRB_W] = b[STRB_W:1];
      WLAST_M[m] = b[0];
    end
    #1;
    rdy_obs = WREADY_M;
    vld_obs = WVALID;
    rdy_bit = SLICE ? (inflight < 2) : wready;
    rdy_exp = '0;
    vld_exp = 1'b0;
    if (gq.size() != 0) begin
      rdy_exp[gq[0]] = rdy_bit;
      vld_exp = WVALID_M[gq[0]];
    end
    if (SLICE) vld_exp = (inflight != 0);
    idle_chk = SLICE ? (inflight == 0) : (gq.size() == 0);
    idle_obs = {WDATA, WSTRB, WLAST};
    beat_obs = idle_obs;
    beat_exp = 'x;
    fire = WVALID && WREADY;
    accept = push && (gq.size() < QDEPTH) && (mid < NUM_M);
    if (fire) begin
      nfire++;
      inflight--;
      if (exp_out.size() != 0) beat_exp = exp_out.pop_front();
    end
    for (int m = 0; m < NUM_M; m++) begin
      if (WVALID_M[m] && WREADY_M[m] && mq[m].size() != 0) begin
        b = mq[m].pop_front();
        inflight++;
        if (b[0] && gq.size() != 0) void'(gq.pop_front());
      end
    end
    if (accept) begin
      gq.push_back(mid);
      for (int k = 0; k < blen; k++) begin
        logic [DATA_W-1:0] d;
        logic [STRB_W-1:0] s;
        d = DATA_W'($urandom);
        s = STRB_W'($urandom);
        b = {d, s, (k == blen - 1)};
        mq[mid].push_back(b);
        exp_out.push_back(b);
      end
    end
  endtask

  task automatic drain(input string tag);
    int cnt;
    cnt = 0;
    while ((gq.size() != 0 || inflight != 0 || exp_out.size() != 0) && cnt < 200) begin
      step(0, 0, 1, '1, 1'b1);
      cnt++;
      if (fire) begin
        n_cmp++; if (beat_obs !== beat_exp) begin n_bad++; $display("FAIL %s_drain_beat: got %h want %h", tag, beat_obs, beat_exp); end
      end
    end
    n_cmp++; if (cnt >= 200) begin n_bad++; $display("FAIL %s_drain_timeout: got %0d cycles want <200", tag, cnt); end
    step(0, 0, 1, '0, 1'b0);
    n_cmp++; if (busy_obs !== busy_exp) begin n_bad++; $display("FAIL %s_drain_busy: got %b want %b", tag, busy_obs, busy_exp); end
  endtask

  task automatic test_reset();
    ARESET = 1'b1; aw_push = 1'b1; aw_mid = '0; WVALID_M = '1; WLAST_M = '1; WREADY = 1'b1;
    WDATA_M = '1; WSTRB_M = '1;
    repeat (3) @(negedge ACLK);
    #1;
    n_cmp++; if (aw_full !== 1'b0) begin n_bad++; $display("FAIL rst_aw_full: got %b want 0", aw_full); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (WVALID !== 1'b0) begin n_bad++; $display("FAIL rst_wvalid: got %b want 0", WVALID); end
    n_cmp++; if (WREADY_M !== '0) begin n_bad++; $display("FAIL rst_wready_m: got %b want 0", WREADY_M); end
    n_cmp++; if ({WDATA, WSTRB, WLAST} !== '0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {WDATA, WSTRB, WLAST}); end
    @(posedge ACLK); #1;
    ARESET = 1'b0; aw_push = 1'b0; WVALID_M = '0;
    clear_model();
    step(1, 1, 2, '0, 1'b0);
    step(0, 0, 1, '0, 1'b0);
    n_cmp++; if (busy_obs !== busy_exp) begin n_bad++; $display("FAIL rst_first_push_busy: got %b want %b", busy_obs, busy_exp); end
    drain("rst");
  endtask

  task automatic test_single_burst();
    step(1, 1, 4, '0, 1'b1);
    nfire = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 3'b010, 1'b1);
      n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL s1_wready_m: got %b want %b", rdy_obs, rdy_exp); end
      n_cmp++; if (rdy_obs !== 3'b010) begin n_bad++; $display("FAIL s1_wready_m_m1: got %b want 010", rdy_obs); end
      n_cmp++; if (vld_obs !== vld_exp) begin n_bad++; $display("FAIL s1_wvalid: got %b want %b", vld_obs, vld_exp); end
      if (fire) begin
        n_cmp++; if (beat_obs !== beat_exp) begin n_bad++; $display("FAIL s1_beat: got %h want %h", beat_obs, beat_exp); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, '0, 1'b1);
      n_cmp++; if (busy_obs !== busy_exp) begin n_bad++; $display("FAIL s1_busy: got %b want %b", busy_obs, busy_exp); end
      if (fire) begin
        n_cmp++; if (beat_obs !== beat_exp) begin n_bad++; $display("FAIL s1_beat_tail: got %h want %h", beat_obs, beat_exp); end
      end
    end
    n_cmp++; if (nfire !== 4) begin n_bad++; $display("FAIL s1_beat_count: got %0d want 4", nfire); end
  endtask

  task automatic test_ordering();
    step(1, 0, 3, '0, 1'b0);
    step(1, 1, 2, '0, 1'b0);
    nfire = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 3'b011, 1'b1);
      n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL ord_wready_m: got %b want %b", rdy_obs, rdy_exp); end
      if (fire) begin
        n_cmp++; if (beat_obs !== beat_exp) begin n_bad++; $display("FAIL ord_beat: got %h want %h", beat_obs, beat_exp); end
      end
    end
    n_cmp++; if (nfire !== 5) begin n_bad++; $display("FAIL ord_beat_count: got %0d want 5", nfire); end
    drain("ord");
  endtask

  task automatic test_full();
    step(1, 2, 1, '0, 1'b0);
    step(1, 0, 1, '0, 1'b0);
    step(1, 1, 1, '0, 1'b0);
    step(1, 2, 1, '0, 1'b0);
    step(1, 1, 1, '0, 1'b0);
    n_cmp++; if (full_obs !== 1'b1 || full_exp !== 1'b1) begin n_bad++; $display("FAIL full_set: got %b want 1", full_obs); end
    step(0, 0, 1, 3'b100, 1'b1);
    n_cmp++; if (full_obs !== full_exp) begin n_bad++; $display("FAIL full_after_drop: got %b want %b", full_obs, full_exp); end
    step(1, 3, 1, '0, 1'b0);
    n_cmp++; if (full_obs !== 1'b0) begin n_bad++; $display("FAIL full_clear: got %b want 0", full_obs); end
    step(0, 0, 1, '0, 1'b0);
    n_cmp++; if (full_obs !== full_exp) begin n_bad++; $display("FAIL full_bad_mid: got %b want %b", full_obs, full_exp); end
    drain("full");
  endtask

  task automatic test_push_pop();
    step(1, 0, 1, '0, 1'b0);
    step(1, 2, 2, 3'b001, 1'b1);
    n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL pp_wready_m0: got %b want %b", rdy_obs, rdy_exp); end
    step(0, 0, 1, 3'b100, 1'b1);
    n_cmp++; if (busy_obs !== 1'b1) begin n_bad++; $display("FAIL pp_busy: got %b want 1", busy_obs); end
    n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL pp_new_head: got %b want %b", rdy_obs, rdy_exp); end
    if (fire) begin
      n_cmp++; if (beat_obs !== beat_exp) begin n_bad++; $display("FAIL pp_beat: got %h want %h", beat_obs, beat_exp); end
    end
    drain("pp");
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] b;
    step(1, 1, 4, '0, 1'b1);
    step(0, 0, 1, 3'b010, 1'b1);
    @(negedge ACLK);
    b = mq[1][0];
    WVALID_M = 3'b010;
    WDATA_M[DATA_W +: DATA_W] = b[BW-1 -: DATA_W];
    WSTRB_M[STRB_W +: STRB_W] = b[STRB_W:1];
    WLAST_M[1] = b[0];
    WREADY = 1'b1;
    #1;
    n_cmp++; if (WVALID !== 1'b1) begin n_bad++; $display("FAIL rm_pre_wvalid: got %b want 1", WVALID); end
    ARESET = 1'b1;
    #1;
    n_cmp++; if (WVALID !== 1'b0) begin n_bad++; $display("FAIL rm_wvalid: got %b want 0", WVALID); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (WREADY_M !== '0) begin n_bad++; $display("FAIL rm_wready_m: got %b want 0", WREADY_M); end
    clear_model();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    nfire = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, '1, 1'b1);
      n_cmp++; if (vld_obs !== 1'b0) begin n_bad++; $display("FAIL rm_no_beats: got %b want 0", vld_obs); end
    end
    n_cmp++; if (nfire !== 0) begin n_bad++; $display("FAIL rm_fire_count: got %0d want 0", nfire); end
    step(1, 0, 2, '0, 1'b0);
    drain("rm");
  endtask

`ifdef W_MUX_REG_SLICE_EN
  task automatic test_slice_latency();
    step(1, 0, 3, '0, 1'b0);
    nfire = 0;
    step(0, 0, 1, 3'b001, 1'b1);
    n_cmp++; if (vld_obs !== 1'b0) begin n_bad++; $display("FAIL sl_lat0: got %b want 0", vld_obs); end
    step(0, 0, 1, 3'b001, 1'b0);
    n_cmp++; if (vld_obs !== 1'b1) begin n_bad++; $display("FAIL sl_lat1: got %b want 1", vld_obs); end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 3'b001, (i % 2) == 0);
      if (fire) begin
        n_cmp++; if (beat_obs !== beat_exp) begin n_bad++; $display("FAIL sl_beat: got %h want %h", beat_obs, beat_exp); end
      end
    end
    n_cmp++; if (nfire !== 3) begin n_bad++; $display("FAIL sl_beat_count: got %0d want 3", nfire); end
    drain("sl");
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(1, 4),
           NUM_M'($urandom), $urandom_range(0, 3) != 0);
      n_cmp++; if (rdy_obs !== rdy_exp) begin n_bad++; $display("FAIL rnd_wready_m: got %b want %b", rdy_obs, rdy_exp); end
      n_cmp++; if (vld_obs !== vld_exp) begin n_bad++; $display("FAIL rnd_wvalid: got %b want %b", vld_obs, vld_exp); end
      n_cmp++; if (full_obs !== full_exp) begin n_bad++; $display("FAIL rnd_aw_full: got %b want %b", full_obs, full_exp); end
      n_cmp++; if (busy_obs !== busy_exp) begin n_bad++; $display("FAIL rnd_busy: got %b want %b", busy_obs, busy_exp); end
      if (fire) begin
        n_cmp++; if (beat_obs !== beat_exp) begin n_bad++; $display("FAIL rnd_beat: got %h want %h", beat_obs, beat_exp); end
      end
      if (idle_chk) begin
        n_cmp++; if (idle_obs !== '0) begin n_bad++; $display("FAIL rnd_idle_zero: got %h want 0", idle_obs); end
      end
    end
    drain("rnd");
    n_cmp++; if (exp_out.size() != 0) begin n_bad++; $display("FAIL rnd_leftover: got %0d beats want 0", exp_out.size()); end
  endtask

  initial begin
    ARESET = 1'b1; aw_push = 1'b0; aw_mid = '0; WDATA_M = '0; WSTRB_M = '0;
    WLAST_M = '0; WVALID_M = '0; WREADY = 1'b0;
    clear_model();
    nfire = 0;
    test_reset();
    test_single_burst();
    test_ordering();
    test_full();
    test_push_pop();
    test_reset_mid();
`ifdef W_MUX_REG_SLICE_EN
    test_slice_latency();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
